// File: rtl/mna_pkg.sv
// ---------------------------------------------------------------------------
// mna_pkg
// Definitions shared by the MNA response-flow sequencer: NoC flit type codes,
// header field positions, AXI response codes and the sequencer state type.
// ---------------------------------------------------------------------------
package mna_pkg;

    // Flit type codes, carried in the two MSBs of every flit
    localparam logic [1:0] FLIT_HDR = 2'b10;
    localparam logic [1:0] FLIT_PLD = 2'b01;

    // Header flit field positions
    localparam int HDR_RD_BIT   = 0;   // 1 = read response, 0 = write response
    localparam int HDR_RESP_LSB = 1;
    localparam int HDR_RESP_MSB = 2;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        R_OUT,
        B_OUT
    } state_t;

endpackage

// File: rtl/mna_flit_decode.sv
// ---------------------------------------------------------------------------
// mna_flit_decode
// Purely combinational classifier for one incoming response flit.
//   i_flit     : raw NoC flit
//   o_is_hdr   : flit type is header
//   o_is_pld   : flit type is payload
//   o_is_rd    : header read flag (meaningful only when o_is_hdr)
//   o_resp     : header response code (meaningful only when o_is_hdr)
//   o_payload  : payload data (meaningful only when o_is_pld)
// ---------------------------------------------------------------------------
module mna_flit_decode
    import mna_pkg::*;
#(
    parameter int FLIT_W = 37,
    parameter int DATA_W = 32
) (
    input  logic [FLIT_W-1:0] i_flit,
    output logic              o_is_hdr,
    output logic              o_is_pld,
    output logic              o_is_rd,
    output logic [1:0]        o_resp,
    output logic [DATA_W-1:0] o_payload
);

    logic [1:0] w_type;
    // Bits between the payload and the type field carry nothing for responses
    logic       w_unused_bits;

    assign w_type        = i_flit[FLIT_W-1:FLIT_W-2];
    assign o_is_hdr      = (w_type == FLIT_HDR);
    assign o_is_pld      = (w_type == FLIT_PLD);
    assign o_is_rd       = i_flit[HDR_RD_BIT];
    assign o_resp        = i_flit[HDR_RESP_MSB:HDR_RESP_LSB];
    assign o_payload     = i_flit[DATA_W-1:0];
    assign w_unused_bits = ^i_flit[FLIT_W-3:DATA_W];

endmodule

// File: rtl/mna_resp_ctrl.sv
// ---------------------------------------------------------------------------
// mna_resp_ctrl
// Response-flow sequencer of the master network adapter. Takes response
// flits from the NoC, turns each packet into exactly one AXI4-Lite R or B
// beat, times out reads whose payload never arrives, and counts framing
// errors.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_noc_data/valid    : incoming flit and its valid
//   o_noc_ready         : flit accepted this cycle when valid is also high
//   o_rdata/rresp/rvalid, i_rready : AXI R channel
//   o_bresp/bvalid, i_bready       : AXI B channel
//   o_err_pulse         : one-cycle pulse per framing error
//   o_err_cnt           : saturating framing-error count
// ---------------------------------------------------------------------------
module mna_resp_ctrl
    import mna_pkg::*;
#(
    parameter int FLIT_W = 37,
    parameter int DATA_W = 32,
    parameter int TO_CYC = 255,
    parameter int TO_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [FLIT_W-1:0] i_noc_data,
    input  logic              i_noc_valid,
    output logic              o_noc_ready,
    output logic [DATA_W-1:0] o_rdata,
    output logic [1:0]        o_rresp,
    output logic              o_rvalid,
    input  logic              i_rready,
    output logic [1:0]        o_bresp,
    output logic              o_bvalid,
    input  logic              i_bready,
    output logic              o_err_pulse,
    output logic [7:0]        o_err_cnt
);

    // Counter value seen on the last idle cycle before the timeout fires
    localparam logic [TO_W-1:0] TO_LAST = (TO_CYC == 0) ? '0 : TO_W'(TO_CYC - 1);

    state_t            r_state;
    logic              r_noc_ready;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic              r_rvalid;
    logic [1:0]        r_bresp;
    logic              r_bvalid;
    logic              r_err_pulse;
    logic [7:0]        r_err_cnt;
    logic [TO_W-1:0]   r_to_cnt;

    logic              w_is_hdr;
    logic              w_is_pld;
    logic              w_is_rd;
    logic [1:0]        w_resp;
    logic [DATA_W-1:0] w_payload;
    logic              w_accept;
    logic              w_taking;    // state that can take a new flit
    logic              w_timeout;
    logic              w_frame_err;

    mna_flit_decode #(
        .FLIT_W (FLIT_W),
        .DATA_W (DATA_W)
    ) u_decode (
        .i_flit    (i_noc_data),
        .o_is_hdr  (w_is_hdr),
        .o_is_pld  (w_is_pld),
        .o_is_rd   (w_is_rd),
        .o_resp    (w_resp),
        .o_payload (w_payload)
    );

    assign w_accept = i_noc_valid && r_noc_ready;
    assign w_taking = (r_state == IDLE) || (r_state == WAIT_DATA);

    // An accept in the same cycle always wins over the timeout
    assign w_timeout = (TO_CYC != 0) && (r_state == WAIT_DATA) && !w_accept &&
                       (r_to_cnt == TO_LAST);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_frame_err = w_timeout;
        if (w_accept && w_taking) begin
            if (w_is_hdr) begin
                // A header while waiting for a payload abandons the old read
                if (r_state == WAIT_DATA) w_frame_err = 1'b1;
            end else if (!(w_is_pld && r_state == WAIT_DATA)) begin
                w_frame_err = 1'b1;
            end
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_noc_ready <= 1'b0;
            r_rdata     <= '0;
            r_rresp     <= RESP_OKAY;
            r_rvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_bvalid    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
            r_to_cnt    <= '0;
        end else begin
            r_err_pulse <= w_frame_err;
            if (w_frame_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;

            case (r_state)
                IDLE, WAIT_DATA: begin
                    r_noc_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_is_hdr && w_is_rd) begin
                            r_rresp  <= w_resp;
                            r_to_cnt <= '0;
                            r_state  <= WAIT_DATA;
                        end else if (w_is_hdr) begin
                            r_bresp     <= w_resp;
                            r_bvalid    <= 1'b1;
                            r_noc_ready <= 1'b0;
                            r_state     <= B_OUT;
                        end else if (w_is_pld && r_state == WAIT_DATA) begin
                            r_rdata     <= w_payload;
                            r_rvalid    <= 1'b1;
                            r_noc_ready <= 1'b0;
                            r_state     <= R_OUT;
                        end
                        // Anything else is dropped; state and counter hold
                    end else if (w_timeout) begin
                        r_rdata     <= '0;
                        r_rresp     <= RESP_SLVERR;
                        r_rvalid    <= 1'b1;
                        r_noc_ready <= 1'b0;
                        r_state     <= R_OUT;
                    end else if (r_state == WAIT_DATA) begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                R_OUT: begin
                    if (i_rready) begin
                        r_rvalid    <= 1'b0;
                        r_noc_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                B_OUT: begin
                    if (i_bready) begin
                        r_bvalid    <= 1'b0;
                        r_noc_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_noc_ready = r_noc_ready;
    assign o_rdata     = r_rdata;
    assign o_rresp     = r_rresp;
    assign o_rvalid    = r_rvalid;
    assign o_bresp     = r_bresp;
    assign o_bvalid    = r_bvalid;
    assign o_err_pulse = r_err_pulse;
    assign o_err_cnt   = r_err_cnt;

endmodule

// File: doc/mna_resp_ctrl.md
Name: mna_resp_ctrl

Overview:
- Response-flow sequencer of the master network adapter (MNA) in the NoC-to-AXI4-Lite bridge.
- Accepts response flits from the NoC ingress port with a valid/ready handshake and classifies them: header flit (type 2'b10) or payload flit (type 2'b01).
- Issues exactly one AXI4-Lite R beat (read) or B beat (write) per response packet to the attached AXI master.
- Registers all outputs, buffers one response, and detects packet-framing errors.

Parameters:
- FLIT_W, 37, NoC flit width; type field is [FLIT_W-1:FLIT_W-2].
- DATA_W, 32, AXI data width; payload occupies flit [DATA_W-1:0].
- TO_CYC, 255, max cycles waiting for a payload after a read header; 0 disables the timeout.
- TO_W, 8, timeout counter width; must satisfy 2**TO_W > TO_CYC.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- noc_data  in  FLIT_W  incoming response flit.
- noc_valid  in  1  flit present.
- noc_ready  out  1  controller accepts the flit this cycle.
- rdata  out  DATA_W  AXI R data.
- rresp  out  2  AXI R response.
- rvalid  out  1  AXI R valid.
- rready  in  1  AXI R ready.
- bresp  out  2  AXI B response.
- bvalid  out  1  AXI B valid.
- bready  in  1  AXI B ready.
- err_pulse  out  1  one-cycle pulse on a framing error.
- err_cnt  out  8  saturating framing-error count.

Behaviour:
- Flit accept occurs when noc_valid && noc_ready. Header fields: bit0 = read flag (1 = read, 0 = write); bits[2:1] = resp code.
- Reset (rst=1 at a clock edge) forces:
  - state = IDLE
  - noc_ready = 0, rvalid = 0, bvalid = 0
  - rdata = 0, rresp = 0, bresp = 0
  - err_pulse = 0, err_cnt = 0, timeout counter = 0
- Reset mid-packet discards the held header and any pending R/B beat without emitting it.
- noc_ready is registered: 1 in IDLE and WAIT_DATA, 0 in R_OUT and B_OUT. The cycle after reset deasserts, noc_ready = 1.
- IDLE:
  - Write header accepted -> bresp <= bits[2:1], bvalid <= 1, go to B_OUT.
  - Read header accepted -> latch rresp <= bits[2:1], clear the timeout counter, go to WAIT_DATA.
  - Payload or type 2'b00/2'b11 accepted -> drop it, framing error, stay in IDLE.
- WAIT_DATA:
  - Payload accepted -> rdata <= flit[DATA_W-1:0], rvalid <= 1, go to R_OUT.
  - Header accepted -> framing error. The old read is abandoned and the new header is processed as in IDLE in the same cycle.
  - Other types -> framing error, stay in WAIT_DATA.
  - Timeout counter increments each cycle without an accept. When it reaches TO_CYC (TO_CYC != 0): rdata <= 0, rresp <= 2'b10 (SLVERR), rvalid <= 1, framing error, go to R_OUT.
- R_OUT: hold rdata, rresp and rvalid stable until rready. On rvalid && rready: rvalid <= 0, noc_ready <= 1, go to IDLE.
- B_OUT: same as R_OUT with bvalid, bready and bresp.
- Latency:
  - Write header accepted at cycle N -> bvalid = 1 at N+1.
  - Payload accepted at N -> rvalid = 1 at N+1.
  - Minimum packet spacing is handshake cycle + 1 (noc_ready returns the cycle after the AXI handshake).
- rvalid and bvalid are never both 1. Neither valid deasserts without its handshake, except on reset.
- Framing error: err_pulse = 1 for exactly the next cycle; err_cnt increments and saturates at 255.
- If a timeout and an accept coincide in the same cycle, the accept wins.

Decomposition:
- Shared package mna_pkg:
  - flit type constants FLIT_HDR = 2'b10, FLIT_PLD = 2'b01
  - header bit positions (read flag, resp field)
  - AXI resp constants OKAY, EXOKAY, SLVERR, DECERR
  - state enum IDLE, WAIT_DATA, R_OUT, B_OUT
- One natural sub-module: mna_flit_decode, a combinational classifier outputting is_hdr, is_pld, is_rd, resp and payload. The FSM, the timeout counter and the output registers stay in mna_resp_ctrl.

Test Plan:
- Write response: hdr flit {2'b10, ..., resp=00, rd=0} with bready=1 -> bvalid=1 one cycle later, bresp=00, noc_ready back to 1 next cycle, err_cnt=0.
- Read response: hdr rd=1, resp=01, then payload 0xDEADBEEF with rready held 0 for 5 cycles -> rdata=0xDEADBEEF, rresp=01 stable while rvalid=1, noc_ready=0 throughout; beat completes when rready=1.
- Orphan payload in IDLE: payload 0x12345678 -> no rvalid, err_pulse for 1 cycle, err_cnt=1.
- Timeout: TO_CYC=4, read hdr then no flits -> after 4 cycles rvalid=1, rdata=0, rresp=10, err_cnt+1.
- Header in WAIT_DATA: read hdr, then write hdr resp=11 -> err_cnt+1, bvalid=1 with bresp=11, no rvalid.
- Reset while rvalid=1 and rready=0 -> next cycle rvalid=0, state IDLE, err_cnt=0, noc_ready=1.
